cg_address_sequencer: RTL and testbench

Parametrised address and phase sequencer for the conjugate-gradient datapath. It generates read and write addresses for NUM_CHANNELS vector memories (P, R, X, P_v2, …) plus the matrix-A stream. It tracks per-phase and per-iteration progress, and raises halt on global completion. It replaces hand-written per-memory counters with uniform channels that have a per-channel wrap/one-pass mode, and sits between the ALU phase controller and the vector/matrix memories.

---
 rtl/cg_address_sequencer_if.sv | 40 ++++
 rtl/cg_address_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_cg_address_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cg_address_sequencer_if.sv
// Handshake/bus bundle between the ALU phase controller and the CG address sequencer.
// Inputs to the sequencer carry an i_ prefix, outputs an o_ prefix.
interface cg_address_sequencer_if #(
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned ITER_WIDTH   = 11
);
   logic                               i_start;
   logic [31:0]                        i_total;
   logic [NUM_CHANNELS-1:0]            i_rd_step;
   logic [NUM_CHANNELS-1:0]            i_wr_step;
   logic [NUM_CHANNELS-1:0]            i_one_pass;
   logic                               i_a_step;
   logic                               i_phase_done;
   logic                               i_finish_all;
   logic [NUM_CHANNELS*ADDR_WIDTH-1:0] o_rd_addr;
   logic [NUM_CHANNELS*ADDR_WIDTH-1:0] o_wr_addr;
   logic [NUM_CHANNELS-1:0]            o_rd_wrap;
   logic [NUM_CHANNELS-1:0]            o_wr_wrap;
   logic [NUM_CHANNELS-1:0]            o_rd_done;
   logic [ADDR_WIDTH-1:0]              o_a_addr;
   logic [ITER_WIDTH-1:0]              o_iteration_count;
   logic                               o_halt;
   logic                               o_busy;
   logic                               o_cfg_err;

   modport slave (
      input  i_start, i_total, i_rd_step, i_wr_step, i_one_pass,
             i_a_step, i_phase_done, i_finish_all,
      output o_rd_addr, o_wr_addr, o_rd_wrap, o_wr_wrap, o_rd_done,
             o_a_addr, o_iteration_count, o_halt, o_busy, o_cfg_err
   );

   modport master (
      output i_start, i_total, i_rd_step, i_wr_step, i_one_pass,
             i_a_step, i_phase_done, i_finish_all,
      input  o_rd_addr, o_wr_addr, o_rd_wrap, o_wr_wrap, o_rd_done,
             o_a_addr, o_iteration_count, o_halt, o_busy, o_cfg_err
   );
endinterface

// File: rtl/cg_address_sequencer.sv
// Address/phase sequencer for the CG datapath: uniform wrap/one-pass vector channels,
// matrix-A stream, phase and iteration tracking, halt on convergence.
module cg_address_sequencer #(
   parameter int unsigned NO_OF_UNITS     = 8,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned NUM_CHANNELS    = 4,
   parameter int unsigned PHASES_PER_ITER = 5,
   parameter int unsigned ITER_WIDTH      = 11
) (
   input logic                   i_clk,
   input logic                   i_reset,
   cg_address_sequencer_if.slave bus
);
   localparam int unsigned PH_W  = $clog2(PHASES_PER_ITER + 1);
   localparam int unsigned PRD_W = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;
   localparam int unsigned VW    = NUM_CHANNELS * ADDR_WIDTH;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PHASE_END, ST_HALT} state_t;

   state_t                  r_state, w_state;
   logic [ADDR_WIDTH-1:0]   r_depth, w_depth;
   logic [ADDR_WIDTH-1:0]   r_a_limit, w_a_limit;
   logic [VW-1:0]           r_rd_addr, w_rd_addr;
   logic [VW-1:0]           r_wr_addr, w_wr_addr;
   logic [NUM_CHANNELS-1:0] r_rd_wrap, w_rd_wrap;
   logic [NUM_CHANNELS-1:0] r_wr_wrap, w_wr_wrap;
   logic [NUM_CHANNELS-1:0] r_rd_done, w_rd_done;
   logic [ADDR_WIDTH-1:0]   r_a_addr, w_a_addr;
   logic [PH_W-1:0]         r_phase, w_phase;
   logic [ITER_WIDTH-1:0]   r_iter, w_iter;
   logic                    r_halt, w_halt;
   logic                    r_busy, w_busy;
   logic                    r_cfg_err, w_cfg_err;
   logic [31:0]             w_depth_full;
   logic [ADDR_WIDTH-1:0]   w_last;
   logic [PH_W-1:0]         w_phase_inc;

   assign w_depth_full = bus.i_total / 32'(NO_OF_UNITS);
   assign w_last       = r_depth - ADDR_WIDTH'(1);
   assign w_phase_inc  = r_phase + PH_W'(1);

   // State and all registered outputs
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state   <= ST_IDLE;
         r_depth   <= '0;
         r_a_limit <= '0;
         r_rd_addr <= '0;
         r_wr_addr <= '0;
         r_rd_wrap <= '0;
         r_wr_wrap <= '0;
         r_rd_done <= '0;
         r_a_addr  <= '0;
         r_phase   <= '0;
         r_iter    <= '0;
         r_halt    <= 1'b0;
         r_busy    <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_depth   <= w_depth;
         r_a_limit <= w_a_limit;
         r_rd_addr <= w_rd_addr;
         r_wr_addr <= w_wr_addr;
         r_rd_wrap <= w_rd_wrap;
         r_wr_wrap <= w_wr_wrap;
         r_rd_done <= w_rd_done;
         r_a_addr  <= w_a_addr;
         r_phase   <= w_phase;
         r_iter    <= w_iter;
         r_halt    <= w_halt;
         r_busy    <= w_busy;
         r_cfg_err <= w_cfg_err;
      end
   end

   // Next state; event priority is finish_all > phase_done > start > steps
   always_comb begin
      w_state   = r_state;
      w_depth   = r_depth;
      w_a_limit = r_a_limit;
      w_rd_addr = r_rd_addr;
      w_wr_addr = r_wr_addr;
      w_rd_wrap = '0;
      w_wr_wrap = '0;
      w_rd_done = r_rd_done;
      w_a_addr  = r_a_addr;
      w_phase   = r_phase;
      w_iter    = r_iter;
      w_halt    = r_halt;
      w_cfg_err = 1'b0;

      case (r_state)
         ST_IDLE, ST_HALT: begin
            if (bus.i_start) begin
               if (w_depth_full == 32'd0) begin
                  w_cfg_err = 1'b1;
               end else begin
                  w_depth   = ADDR_WIDTH'(w_depth_full);
                  w_a_limit = ADDR_WIDTH'(PRD_W'(w_depth_full) * PRD_W'(bus.i_total));
                  w_rd_addr = '0;
                  w_wr_addr = '0;
                  w_rd_done = '0;
                  w_a_addr  = '0;
                  w_phase   = '0;
                  w_iter    = '0;
                  w_halt    = 1'b0;
                  w_state   = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (bus.i_finish_all) begin
               w_iter  = r_iter + ITER_WIDTH'(1);
               w_halt  = 1'b1;
               w_state = ST_HALT;
            end else if (bus.i_phase_done) begin
               w_rd_addr = '0;
               w_wr_addr = '0;
               w_rd_done = '0;
               w_a_addr  = '0;
               if (w_phase_inc == PH_W'(PHASES_PER_ITER)) begin
                  w_phase = '0;
                  w_iter  = r_iter + ITER_WIDTH'(1);
               end else begin
                  w_phase = w_phase_inc;
               end
               w_state = ST_PHASE_END;
            end else begin
               for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                  // A finished one-pass channel parks at 0 until the next phase
                  if (bus.i_rd_step[c] && !r_rd_done[c]) begin
                     if (r_rd_addr[c*ADDR_WIDTH +: ADDR_WIDTH] == w_last) begin
                        w_rd_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = '0;
                        w_rd_wrap[c] = 1'b1;
                        if (bus.i_one_pass[c]) w_rd_done[c] = 1'b1;
                     end else begin
                        w_rd_addr[c*ADDR_WIDTH +: ADDR_WIDTH] =
                           r_rd_addr[c*ADDR_WIDTH +: ADDR_WIDTH] + ADDR_WIDTH'(1);
                     end
                  end
                  if (bus.i_wr_step[c]) begin
                     if (r_wr_addr[c*ADDR_WIDTH +: ADDR_WIDTH] == w_last) begin
                        w_wr_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = '0;
                        w_wr_wrap[c] = 1'b1;
                     end else begin
                        w_wr_addr[c*ADDR_WIDTH +: ADDR_WIDTH] =
                           r_wr_addr[c*ADDR_WIDTH +: ADDR_WIDTH] + ADDR_WIDTH'(1);
                     end
                  end
               end
               if (bus.i_a_step) begin
                  if (r_a_addr == r_a_limit - ADDR_WIDTH'(1)) w_a_addr = '0;
                  else                                        w_a_addr = r_a_addr + ADDR_WIDTH'(1);
               end
            end
         end
         ST_PHASE_END: begin
            if (bus.i_finish_all) begin
               w_iter  = r_iter + ITER_WIDTH'(1);
               w_halt  = 1'b1;
               w_state = ST_HALT;
            end else begin
               w_state = ST_RUN;
            end
         end
         default: w_state = ST_IDLE;
      endcase

      w_busy = (w_state == ST_RUN) || (w_state == ST_PHASE_END);
   end

   assign bus.o_rd_addr         = r_rd_addr;
   assign bus.o_wr_addr         = r_wr_addr;
   assign bus.o_rd_wrap         = r_rd_wrap;
   assign bus.o_wr_wrap         = r_wr_wrap;
   assign bus.o_rd_done         = r_rd_done;
   assign bus.o_a_addr          = r_a_addr;
   assign bus.o_iteration_count = r_iter;
   assign bus.o_halt            = r_halt;
   assign bus.o_busy            = r_busy;
   assign bus.o_cfg_err         = r_cfg_err;
endmodule

// File: tb/tb_cg_address_sequencer.sv
// Directed self-checking bench for cg_address_sequencer with hand-computed expectations.
module tb_cg_address_sequencer;
   localparam int unsigned NU  = 8;
   localparam int unsigned AW  = 32;
   localparam int unsigned NC  = 4;
   localparam int unsigned PPI = 5;
   localparam int unsigned IW  = 11;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   cg_address_sequencer_if #(.NUM_CHANNELS(NC), .ADDR_WIDTH(AW), .ITER_WIDTH(IW)) bus ();

   cg_address_sequencer #(
      .NO_OF_UNITS(NU), .ADDR_WIDTH(AW), .NUM_CHANNELS(NC),
      .PHASES_PER_ITER(PPI), .ITER_WIDTH(IW)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [AW-1:0] rd_a(int c);
      return bus.o_rd_addr[c*AW +: AW];
   endfunction

   function automatic logic [AW-1:0] wr_a(int c);
      return bus.o_wr_addr[c*AW +: AW];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.i_start      = 1'b0;
      bus.i_total      = '0;
      bus.i_rd_step    = '0;
      bus.i_wr_step    = '0;
      bus.i_one_pass   = '0;
      bus.i_a_step     = 1'b0;
      bus.i_phase_done = 1'b0;
      bus.i_finish_all = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic do_start(input logic [31:0] total);
      bus.i_start = 1'b1;
      bus.i_total = total;
      tick();
      bus.i_start = 1'b0;
      bus.i_total = 32'hDEAD_BEEF;
   endtask

   task automatic pulse_phase();
      bus.i_phase_done = 1'b1;
      tick();
      bus.i_phase_done = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      n_vec++;
      if (bus.o_rd_addr !== '0 || bus.o_wr_addr !== '0) begin
         n_err++; $display("FAIL reset_addr rd=%h wr=%h expected 0", bus.o_rd_addr, bus.o_wr_addr);
      end
      n_vec++;
      if ({bus.o_rd_wrap, bus.o_wr_wrap, bus.o_rd_done} !== '0) begin
         n_err++; $display("FAIL reset_flags got %b expected 0", {bus.o_rd_wrap, bus.o_wr_wrap, bus.o_rd_done});
      end
      n_vec++;
      if ({bus.o_a_addr, bus.o_iteration_count, bus.o_halt, bus.o_busy, bus.o_cfg_err} !== '0) begin
         n_err++; $display("FAIL reset_misc a=%0d it=%0d halt=%b busy=%b cfg=%b expected all 0",
                           bus.o_a_addr, bus.o_iteration_count, bus.o_halt, bus.o_busy, bus.o_cfg_err);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_free_wrap();
      logic [AW-1:0] exp_rd [6];
      logic [AW-1:0] exp_wr [6];
      exp_rd = '{1, 2, 3, 0, 1, 2};
      exp_wr = '{1, 2, 3, 3, 3, 3};
      do_start(32);
      n_vec++;
      if (bus.o_busy !== 1'b1) begin
         n_err++; $display("FAIL start_busy got %b expected 1", bus.o_busy);
      end
      for (int i = 0; i < 6; i++) begin
         bus.i_rd_step = 4'b0001;
         bus.i_wr_step = (i < 3) ? 4'b0001 : 4'b0000;
         tick();
         n_vec++;
         if (rd_a(0) !== exp_rd[i] || bus.o_rd_wrap[0] !== (i == 3)) begin
            n_err++; $display("FAIL free_wrap_rd step%0d addr=%0d wrap=%b expected addr=%0d wrap=%b",
                              i, rd_a(0), bus.o_rd_wrap[0], exp_rd[i], (i == 3));
         end
         n_vec++;
         if (wr_a(0) !== exp_wr[i] || bus.o_wr_wrap[0] !== 1'b0) begin
            n_err++; $display("FAIL free_wrap_wr step%0d addr=%0d wrap=%b expected addr=%0d wrap=0",
                              i, wr_a(0), bus.o_wr_wrap[0], exp_wr[i]);
         end
      end
      bus.i_rd_step = '0;
      bus.i_wr_step = '0;
   endtask

   task automatic test_one_pass();
      logic [AW-1:0] exp_rd [6];
      exp_rd = '{1, 2, 3, 0, 0, 0};
      bus.i_one_pass = 4'b0010;
      for (int i = 0; i < 6; i++) begin
         bus.i_rd_step = 4'b0010;
         tick();
         n_vec++;
         if (rd_a(1) !== exp_rd[i] || bus.o_rd_done[1] !== (i >= 3) || bus.o_rd_wrap[1] !== (i == 3)) begin
            n_err++; $display("FAIL one_pass step%0d addr=%0d done=%b wrap=%b expected addr=%0d done=%b wrap=%b",
                              i, rd_a(1), bus.o_rd_done[1], bus.o_rd_wrap[1], exp_rd[i], (i >= 3), (i == 3));
         end
      end
      bus.i_phase_done = 1'b1;
      tick();
      bus.i_phase_done = 1'b0;
      n_vec++;
      if (bus.o_rd_done[1] !== 1'b0 || rd_a(0) !== '0 || wr_a(0) !== '0 || bus.o_busy !== 1'b1) begin
         n_err++; $display("FAIL phase_clear done1=%b rd0=%0d wr0=%0d busy=%b expected 0,0,0,1",
                           bus.o_rd_done[1], rd_a(0), wr_a(0), bus.o_busy);
      end
      tick();
      n_vec++;
      if (rd_a(1) !== '0) begin
         n_err++; $display("FAIL phase_end_step addr=%0d expected 0", rd_a(1));
      end
      tick();
      n_vec++;
      if (rd_a(1) !== 32'd1) begin
         n_err++; $display("FAIL one_pass_resume addr=%0d expected 1", rd_a(1));
      end
      bus.i_rd_step  = '0;
      bus.i_one_pass = '0;
   endtask

   task automatic test_iteration();
      do_reset();
      do_start(16);
      for (int p = 1; p <= 10; p++) begin
         bus.i_rd_step    = 4'b0001;
         bus.i_phase_done = 1'b1;
         tick();
         bus.i_phase_done = 1'b0;
         tick();
         n_vec++;
         if (rd_a(0) !== '0) begin
            n_err++; $display("FAIL iter_phase_end_step phase%0d addr=%0d expected 0", p, rd_a(0));
         end
         bus.i_rd_step = '0;
         tick();
         if (p == 5) begin
            n_vec++;
            if (bus.o_iteration_count !== IW'(1)) begin
               n_err++; $display("FAIL iter_count_5 got %0d expected 1", bus.o_iteration_count);
            end
         end
      end
      n_vec++;
      if (bus.o_iteration_count !== IW'(2)) begin
         n_err++; $display("FAIL iter_count_10 got %0d expected 2", bus.o_iteration_count);
      end
   endtask

   task automatic test_priority();
      do_reset();
      do_start(32);
      for (int p = 0; p < 3; p++) pulse_phase();
      bus.i_rd_step = 4'b0100;
      bus.i_a_step  = 1'b1;
      tick();
      bus.i_a_step  = 1'b0;
      tick();
      bus.i_rd_step = '0;
      bus.i_finish_all = 1'b1;
      bus.i_phase_done = 1'b1;
      tick();
      bus.i_finish_all = 1'b0;
      bus.i_phase_done = 1'b0;
      n_vec++;
      if (bus.o_halt !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_iteration_count !== IW'(1)) begin
         n_err++; $display("FAIL prio_halt halt=%b busy=%b it=%0d expected 1,0,1",
                           bus.o_halt, bus.o_busy, bus.o_iteration_count);
      end
      n_vec++;
      if (rd_a(2) !== 32'd2 || bus.o_a_addr !== 32'd1) begin
         n_err++; $display("FAIL prio_addr rd2=%0d a=%0d expected 2,1", rd_a(2), bus.o_a_addr);
      end
      bus.i_rd_step = 4'b0100;
      bus.i_a_step  = 1'b1;
      tick();
      tick();
      bus.i_rd_step = '0;
      bus.i_a_step  = 1'b0;
      n_vec++;
      if (rd_a(2) !== 32'd2 || bus.o_a_addr !== 32'd1 || bus.o_halt !== 1'b1) begin
         n_err++; $display("FAIL halt_ignores_steps rd2=%0d a=%0d halt=%b expected 2,1,1",
                           rd_a(2), bus.o_a_addr, bus.o_halt);
      end
   endtask

   task automatic test_cfg_err();
      do_start(7);
      n_vec++;
      if (bus.o_cfg_err !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_halt !== 1'b1) begin
         n_err++; $display("FAIL cfg_err_pulse cfg=%b busy=%b halt=%b expected 1,0,1",
                           bus.o_cfg_err, bus.o_busy, bus.o_halt);
      end
      tick();
      n_vec++;
      if (bus.o_cfg_err !== 1'b0) begin
         n_err++; $display("FAIL cfg_err_one_cycle got %b expected 0", bus.o_cfg_err);
      end
      do_start(64);
      n_vec++;
      if (bus.o_busy !== 1'b1 || bus.o_halt !== 1'b0 || bus.o_iteration_count !== '0 || rd_a(2) !== '0) begin
         n_err++; $display("FAIL restart busy=%b halt=%b it=%0d rd2=%0d expected 1,0,0,0",
                           bus.o_busy, bus.o_halt, bus.o_iteration_count, rd_a(2));
      end
      bus.i_a_step = 1'b1;
      for (int i = 1; i <= 512; i++) begin
         tick();
         if (i == 1 || i == 511 || i == 512) begin
            n_vec++;
            if (bus.o_a_addr !== AW'(i % 512)) begin
               n_err++; $display("FAIL a_addr_wrap step%0d got %0d expected %0d", i, bus.o_a_addr, i % 512);
            end
         end
      end
      bus.i_a_step = 1'b0;
   endtask

   task automatic test_async_reset();
      bus.i_rd_step = 4'b0100;
      bus.i_wr_step = 4'b0001;
      bus.i_a_step  = 1'b1;
      tick();
      tick();
      tick();
      n_vec++;
      if (rd_a(2) !== 32'd3) begin
         n_err++; $display("FAIL pre_reset_rd2 got %0d expected 3", rd_a(2));
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.o_rd_addr !== '0 || bus.o_wr_addr !== '0 || bus.o_a_addr !== '0 || bus.o_busy !== 1'b0 ||
          bus.o_iteration_count !== '0 || bus.o_rd_done !== '0 || bus.o_halt !== 1'b0) begin
         n_err++; $display("FAIL async_reset rd=%h wr=%h a=%0d busy=%b it=%0d expected all 0",
                           bus.o_rd_addr, bus.o_wr_addr, bus.o_a_addr, bus.o_busy, bus.o_iteration_count);
      end
      rst_n = 1'b1;
      tick();
      tick();
      n_vec++;
      if (rd_a(2) !== '0 || wr_a(0) !== '0 || bus.o_a_addr !== '0 || bus.o_busy !== 1'b0) begin
         n_err++; $display("FAIL post_reset_idle rd2=%0d wr0=%0d a=%0d busy=%b expected 0,0,0,0",
                           rd_a(2), wr_a(0), bus.o_a_addr, bus.o_busy);
      end
      clear_inputs();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      clear_inputs();
      test_reset();
      test_free_wrap();
      test_one_pass();
      test_iteration();
      test_priority();
      test_cfg_err();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
